// File: rtl/rvv_backend_rob_wb_collector.sv
// rvv_backend_rob_wb_collector
//
// ROB-side collector for processing-unit results. Entries are allocated in
// program order at the tail. Writebacks from NUM_PU execution units may arrive
// out of order and are captured into the addressed entry. Completed entries
// are handed to the commit stage strictly in allocation order from the head.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   flush             discard all entries (wb_err preserved)
//   alloc_valid/ready dispatch handshake; alloc_entry is the granted index
//   wb_valid          per-port writeback strobe
//   wb_rob_entry      per-port target entry, IDX_W bits per port
//   wb_data           per-port result, VLEN bits per port
//   wb_vsaturate      per-port saturation flags, VLENB bits per port
//   retire_valid/ready head-of-ROB handshake to commit
//   retire_entry/data/vsaturate  head entry contents
//   rob_empty, rob_full  occupancy status
//   wb_err            sticky flag for illegal or colliding writebacks
module rvv_backend_rob_wb_collector #(
    parameter int ROB_DEPTH = 8,
    parameter int NUM_PU    = 2,
    parameter int VLEN      = 128,
    parameter int VLENB     = VLEN / 8,
    parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    output logic [IDX_W-1:0]          alloc_entry,
    input  logic [NUM_PU-1:0]         wb_valid,
    input  logic [NUM_PU*IDX_W-1:0]   wb_rob_entry,
    input  logic [NUM_PU*VLEN-1:0]    wb_data,
    input  logic [NUM_PU*VLENB-1:0]   wb_vsaturate,
    output logic                      retire_valid,
    input  logic                      retire_ready,
    output logic [IDX_W-1:0]          retire_entry,
    output logic [VLEN-1:0]           retire_data,
    output logic [VLENB-1:0]          retire_vsaturate,
    output logic                      rob_empty,
    output logic                      rob_full,
    output logic                      wb_err
);

    // Pointers carry one extra wrap bit to distinguish full from empty.
    logic [IDX_W:0]         head_ptr;
    logic [IDX_W:0]         tail_ptr;
    logic [ROB_DEPTH-1:0]   entry_alloc;
    logic [ROB_DEPTH-1:0]   entry_done;
    logic [VLEN-1:0]        entry_data [ROB_DEPTH];
    logic [VLENB-1:0]       entry_sat  [ROB_DEPTH];
    logic                   wb_err_q;

    logic [IDX_W-1:0]       head_idx;
    logic [IDX_W-1:0]       tail_idx;
    logic                   full;
    logic                   empty;
    logic                   alloc_fire;
    logic                   retire_fire;

    logic [IDX_W-1:0]       wb_idx [NUM_PU];
    logic [NUM_PU-1:0]      wb_dup;
    logic [NUM_PU-1:0]      wb_accept;
    logic                   wb_err_set;

    assign head_idx = head_ptr[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];
    assign empty    = (head_ptr == tail_ptr);
    assign full     = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);

    // No same-cycle credit from retire: a full ROB refuses alloc even when
    // the head leaves in that cycle.
    assign alloc_ready  = !full;
    assign alloc_entry  = tail_idx;
    assign alloc_fire   = alloc_valid && alloc_ready;

    assign retire_valid     = entry_alloc[head_idx] && entry_done[head_idx];
    assign retire_entry     = head_idx;
    assign retire_data      = entry_data[head_idx];
    assign retire_vsaturate = entry_sat[head_idx];
    assign retire_fire      = retire_valid && retire_ready;

    assign rob_empty = empty;
    assign rob_full  = full;
    assign wb_err    = wb_err_q;

    always_comb begin
        for (int p = 0; p < NUM_PU; p++) begin
            wb_idx[p] = wb_rob_entry[p*IDX_W +: IDX_W];
        end
    end

    // A port loses to any lower-numbered valid port aimed at the same entry.
    always_comb begin
        wb_dup = '0;
        for (int p = 1; p < NUM_PU; p++) begin
            for (int q = 0; q < p; q++) begin
                if (wb_valid[q] && (wb_idx[q] == wb_idx[p])) begin
                    wb_dup[p] = 1'b1;
                end
            end
        end
    end

    // The entry being allocated this cycle still reads as unallocated here,
    // so a writeback to it is rejected as an error.
    always_comb begin
        wb_accept  = '0;
        wb_err_set = 1'b0;
        for (int p = 0; p < NUM_PU; p++) begin
            if (wb_valid[p]) begin
                if (entry_alloc[wb_idx[p]] && !entry_done[wb_idx[p]] && !wb_dup[p]) begin
                    wb_accept[p] = 1'b1;
                end else begin
                    wb_err_set = 1'b1;
                end
                if (wb_dup[p]) begin
                    wb_err_set = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr    <= '0;
            tail_ptr    <= '0;
            entry_alloc <= '0;
            entry_done  <= '0;
            wb_err_q    <= 1'b0;
        end else if (flush) begin
            head_ptr    <= '0;
            tail_ptr    <= '0;
            entry_alloc <= '0;
            entry_done  <= '0;
        end else begin
            // Retire, alloc and writeback always touch distinct entries:
            // head==tail index only when empty (no retire) or full (no alloc).
            if (retire_fire) begin
                entry_alloc[head_idx] <= 1'b0;
                entry_done[head_idx]  <= 1'b0;
                head_ptr              <= head_ptr + 1'b1;
            end
            if (alloc_fire) begin
                entry_alloc[tail_idx] <= 1'b1;
                entry_done[tail_idx]  <= 1'b0;
                tail_ptr              <= tail_ptr + 1'b1;
            end
            for (int p = 0; p < NUM_PU; p++) begin
                if (wb_accept[p]) begin
                    entry_done[wb_idx[p]] <= 1'b1;
                end
            end
            if (wb_err_set) begin
                wb_err_q <= 1'b1;
            end
        end
    end

    // Payload storage is not reset; it is only observed behind retire_valid.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PU; p++) begin
            if (wb_accept[p] && !rst && !flush) begin
                entry_data[wb_idx[p]] <= wb_data[p*VLEN +: VLEN];
                entry_sat[wb_idx[p]]  <= wb_vsaturate[p*VLENB +: VLENB];
            end
        end
    end

endmodule

// File: tb/tb_rvv_backend_rob_wb_collector.sv
// tb_rvv_backend_rob_wb_collector
//
// Bench for the ROB writeback collector. Allocated entry indices are queued in
// program order; the data each entry should carry is kept in a small model
// array updated whenever a legal writeback is driven. A negedge monitor pops
// the queue on every retire handshake and compares index, data and sat.
module tb_rvv_backend_rob_wb_collector;

    localparam int ROB_DEPTH = 8;
    localparam int NUM_PU    = 2;
    localparam int VLEN      = 128;
    localparam int VLENB     = VLEN / 8;
    localparam int IDX_W     = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [IDX_W-1:0]         alloc_entry;
    logic [NUM_PU-1:0]        wb_valid;
    logic [NUM_PU*IDX_W-1:0]  wb_rob_entry;
    logic [NUM_PU*VLEN-1:0]   wb_data;
    logic [NUM_PU*VLENB-1:0]  wb_vsaturate;
    logic                     retire_valid;
    logic                     retire_ready;
    logic [IDX_W-1:0]         retire_entry;
    logic [VLEN-1:0]          retire_data;
    logic [VLENB-1:0]         retire_vsaturate;
    logic                     rob_empty;
    logic                     rob_full;
    logic                     wb_err;

    int n_tests = 0;
    int n_fail  = 0;
    int mdl_tail;
    int exp_q[$];
    logic [VLEN-1:0]  model_data [ROB_DEPTH];
    logic [VLENB-1:0] model_sat  [ROB_DEPTH];

    always #5 clk = ~clk;

    rvv_backend_rob_wb_collector #(
        .ROB_DEPTH(ROB_DEPTH), .NUM_PU(NUM_PU), .VLEN(VLEN), .VLENB(VLENB), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_entry(alloc_entry),
        .wb_valid(wb_valid), .wb_rob_entry(wb_rob_entry), .wb_data(wb_data),
        .wb_vsaturate(wb_vsaturate),
        .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_entry(retire_entry),
        .retire_data(retire_data), .retire_vsaturate(retire_vsaturate),
        .rob_empty(rob_empty), .rob_full(rob_full), .wb_err(wb_err)
    );

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VLENB-1:0] sat_of(input logic [VLEN-1:0] d);
        return d[23:8] ^ 16'h5a5a;
    endfunction

    always @(negedge clk) begin
        if (!rst && !flush && retire_valid && retire_ready) begin
            if (exp_q.size() == 0) begin
                check("retire_unexpected", 1, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("retire_entry", retire_entry, e);
                check("retire_data", retire_data, model_data[e]);
                check("retire_sat", retire_vsaturate, model_sat[e]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        mdl_tail = 0;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            check("alloc_entry", alloc_entry, mdl_tail % ROB_DEPTH);
            exp_q.push_back(mdl_tail % ROB_DEPTH);
            mdl_tail++;
            alloc_valid = 1'b1;
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    // Drive up to two ports for one cycle; model updates are done by callers.
    task automatic wb2(input bit v0, input int e0, input logic [VLEN-1:0] d0,
                       input bit v1, input int e1, input logic [VLEN-1:0] d1);
        wb_valid     = {v1, v0};
        wb_rob_entry = {e1[IDX_W-1:0], e0[IDX_W-1:0]};
        wb_data      = {d1, d0};
        wb_vsaturate = {sat_of(d1), sat_of(d0)};
        tick();
        wb_valid = '0;
    endtask

    task automatic wb_legal(input int e, input logic [VLEN-1:0] d);
        model_data[e] = d;
        model_sat[e]  = sat_of(d);
        wb2(1'b1, e, d, 1'b0, 0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VLEN-1:0] d;
        int perm[ROB_DEPTH];
        rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0; retire_ready = 1'b0;
        wb_valid = '0; wb_rob_entry = '0; wb_data = '0; wb_vsaturate = '0;
        mdl_tail = 0;

        // Reset values and out-of-order completion with in-order retire.
        do_reset();
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_retire_valid", retire_valid, 0);
        check("rst_empty", rob_empty, 1);
        check("rst_full", rob_full, 0);
        check("rst_wb_err", wb_err, 0);
        retire_ready = 1'b1;
        alloc_n(3);
        wb_legal(2, {16{8'hAA}});
        check("t1_no_retire_yet", retire_valid, 0);
        wb_legal(0, {16{8'hC0}});
        check("t1_retire_latency", retire_valid, 1);
        wb_legal(1, {16{8'h5B}});
        repeat (4) tick();
        check("t1_drained", exp_q.size(), 0);
        check("t1_empty", rob_empty, 1);
        check("t1_wb_err", wb_err, 0);

        // Full ROB, retire and refused alloc in the same cycle, wrap.
        do_reset();
        retire_ready = 1'b0;
        alloc_n(8);
        check("t2_full", rob_full, 1);
        check("t2_alloc_ready", alloc_ready, 0);
        wb_legal(0, {4{32'h0123_4567}});
        alloc_valid  = 1'b1;
        retire_ready = 1'b1;
        tick();
        alloc_valid  = 1'b0;
        retire_ready = 1'b0;
        check("t2_ready_after", alloc_ready, 1);
        check("t2_not_full", rob_full, 0);
        check("t2_head_gone", exp_q.size(), 7);
        alloc_n(1);
        check("t2_full_again", rob_full, 1);

        // Port collision: lowest port wins, error sticks across flush.
        do_reset();
        alloc_n(4);
        model_data[3] = {16{8'h11}};
        model_sat[3]  = sat_of({16{8'h11}});
        wb2(1'b1, 3, {16{8'h11}}, 1'b1, 3, {16{8'h22}});
        check("t3_wb_err", wb_err, 1);
        wb_legal(0, {16{8'h30}});
        wb_legal(1, {16{8'h31}});
        wb_legal(2, {16{8'h32}});
        retire_ready = 1'b1;
        repeat (5) tick();
        retire_ready = 1'b0;
        check("t3_drained", exp_q.size(), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        mdl_tail = 0;
        check("t3_err_after_flush", wb_err, 1);
        check("t3_empty", rob_empty, 1);

        // Writeback to an unallocated entry, then to an already-done entry.
        do_reset();
        wb2(1'b1, 5, {16{8'h77}}, 1'b0, 0, '0);
        check("t4_no_retire", retire_valid, 0);
        check("t4_wb_err", wb_err, 1);
        alloc_n(1);
        wb_legal(0, {16{8'h3C}});
        wb2(1'b0, 0, '0, 1'b1, 0, {16{8'hC3}});
        check("t4_data_kept", retire_data, {16{8'h3C}});
        retire_ready = 1'b1;
        tick();
        retire_ready = 1'b0;
        check("t4_drained", exp_q.size(), 0);

        // Flush wins over a concurrent alloc.
        do_reset();
        alloc_n(4);
        wb_legal(0, {16{8'h40}});
        wb_legal(1, {16{8'h41}});
        flush = 1'b1;
        alloc_valid = 1'b1;
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        exp_q.delete();
        mdl_tail = 0;
        check("t5_empty", rob_empty, 1);
        check("t5_alloc_entry", alloc_entry, 0);
        check("t5_retire_valid", retire_valid, 0);

        // Head held under backpressure, then reset mid-hold.
        do_reset();
        alloc_n(1);
        wb_legal(0, {4{32'hDEAD_BEEF}});
        wb2(1'b1, 4, {16{8'h99}}, 1'b0, 0, '0);
        check("t6_wb_err", wb_err, 1);
        for (int i = 0; i < 5; i++) begin
            check("t6_hold_valid", retire_valid, 1);
            check("t6_hold_entry", retire_entry, 0);
            check("t6_hold_data", retire_data, {4{32'hDEAD_BEEF}});
            tick();
        end
        do_reset();
        check("t6_rst_alloc_ready", alloc_ready, 1);
        check("t6_rst_retire_valid", retire_valid, 0);
        check("t6_rst_empty", rob_empty, 1);
        check("t6_rst_full", rob_full, 0);
        check("t6_rst_wb_err", wb_err, 0);

        // Random completion order across a full ROB.
        do_reset();
        retire_ready = 1'b1;
        alloc_n(8);
        for (int i = 0; i < ROB_DEPTH; i++) perm[i] = i;
        for (int i = ROB_DEPTH - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < ROB_DEPTH; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            wb_legal(perm[i], d);
        end
        repeat (10) tick();
        check("t7_drained", exp_q.size(), 0);
        check("t7_empty", rob_empty, 1);
        check("t7_wb_err", wb_err, 0);
        retire_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rvv_backend_rob_wb_collector.md
Name: rvv_backend_rob_wb_collector

Overview:
Receiving end of the processing-unit-to-ROB result interface. It allocates ROB entries in program order and captures out-of-order writebacks (rob_entry, w_data, vsaturate, w_valid) from NUM_PU execution units. It marks entries done and presents completed entries in order to the retire logic through a valid/ready handshake. It sits between the ALU/MUL/other PU result buses and the commit stage.

Parameters:
ROB_DEPTH, 8, number of entries; power of two, at least 2
NUM_PU, 2, number of writeback ports
VLEN, 128, result data width in bits
VLENB, VLEN/8, vsaturate width (one bit per byte)
IDX_W, $clog2(ROB_DEPTH), entry index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  discard all entries
alloc_valid  in  1  dispatch requests one entry
alloc_ready  out  1  entry available
alloc_entry  out  IDX_W  index granted (tail pointer)
wb_valid  in  NUM_PU  per-port w_valid
wb_rob_entry  in  NUM_PU*IDX_W  per-port target entry
wb_data  in  NUM_PU*VLEN  per-port w_data
wb_vsaturate  in  NUM_PU*VLENB  per-port vsaturate
retire_valid  out  1  head entry allocated and done
retire_ready  in  1  commit accepts head
retire_entry  out  IDX_W  head index
retire_data  out  VLEN  head w_data
retire_vsaturate  out  VLENB  head vsaturate
rob_empty  out  1  count==0
rob_full  out  1  count==ROB_DEPTH
wb_err  out  1  sticky protocol-error flag

Behaviour:
- Clock is clk. Reset is rst, synchronous, active-high. All state is sampled on the rising edge of clk.
- State: head_ptr and tail_ptr, each IDX_W+1 bits with a wrap bit; per-entry alloc, done, data and sat registers; wb_err.
- Reset (rst=1 at an edge): pointers=0, all alloc/done=0, wb_err=0. After reset: alloc_ready=1, retire_valid=0, rob_empty=1, rob_full=0. Data/sat registers are not reset; retire_data/retire_vsaturate are don't-care while retire_valid=0.
- Reset mid-operation discards all entries; it behaves the same as reset.
- count = tail_ptr - head_ptr. full when the indices are equal and the wrap bits differ. empty when the pointers are equal.
- alloc_ready = !full, registered state only. There is no same-cycle credit from retire: a full ROB with a retire that cycle still refuses alloc.
- alloc fire (alloc_valid & alloc_ready): alloc[tail]=1, done[tail]=0, tail_ptr+1 with wrap. alloc_entry = tail index, combinational from state.
- Writeback, per port p with wb_valid[p]:
  - If alloc[e]=1 and done[e]=0: data[e]<=wb_data, sat[e]<=wb_vsaturate, done[e]<=1.
  - Target not allocated, or already done: no state change, wb_err<=1.
  - Two ports targeting the same entry in one cycle: lowest port index wins, wb_err<=1.
- Writeback to the entry being allocated in the same cycle is illegal (not yet allocated) and is handled as the not-allocated case.
- retire_valid = alloc[head] & done[head], registered state. Writeback-to-retire latency is 1 cycle: wb at edge t, retire_valid high after edge t.
- retire fire (retire_valid & retire_ready): alloc[head]=0, done[head]=0, head_ptr+1 with wrap.
- retire_valid must hold, with retire_entry/data/sat stable, until it fires.
- Alloc, writeback and retire may occur in the same cycle on different entries and all take effect. Alloc and retire in the same cycle leave count unchanged.
- Pointer wrap: index ROB_DEPTH-1 increments to 0 with the wrap bit toggled.
- flush=1 (rst=0): same effect as reset except wb_err is preserved. Flush has priority over alloc, wb and retire in that cycle.
- wb_err clears only on rst.
- Out-of-order completion is allowed. Retire order is strictly allocation order.

Test Plan:
- Reset, then alloc 3 entries (0,1,2). Wb entry 2 (data=0xAA..), then 0, then 1 with retire_ready=1 throughout -> retire_valid is first seen 1 cycle after wb to 0; retire_entry sequence 0,1,2 with matching data; rob_empty=1 at end.
- Alloc 8 entries -> rob_full=1, alloc_ready=0. Complete entry 0, then drive alloc_valid and retire_ready in the same cycle -> retire fires, alloc is refused that cycle, alloc_ready=1 on the next cycle, next alloc_entry=0 with wrap.
- Port0 and port1 both write entry 3 in one cycle (data 0x11 vs 0x22) -> entry 3 holds 0x11, wb_err=1 and stays 1 through a later flush.
- Wb to an unallocated entry 5 while empty -> no retire_valid, wb_err=1. A second wb to an already-done entry -> data unchanged.
- Alloc 4, complete 2, assert flush together with alloc_valid -> next cycle rob_empty=1, alloc_entry=0, retire_valid=0.
- Head done with retire_ready=0 for 5 cycles -> retire_valid, retire_entry and retire_data stay constant. Assert rst mid-hold -> all outputs at reset values next cycle, wb_err=0.
